// File: rtl/qgemm_tile_sched.sv
// Job-level sequencer driving one qgemm engine across an M x N output in row-major tile order.
// Load -> start -> wait for the rising edge of engine done -> writeback, per tile; a watchdog bounds the compute wait.
module qgemm_tile_sched #(
    parameter int TILE    = 8,
    parameter int K       = 64,
    parameter int FP_W    = 32,
    parameter int ADDR_W  = 32,
    parameter int DIM_W   = 16,
    parameter int SCALE_W = 16,
    parameter int QBW     = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid_i,
    output logic               job_ready_o,
    input  logic [DIM_W-1:0]   job_m_i,
    input  logic [DIM_W-1:0]   job_n_i,
    input  logic [ADDR_W-1:0]  job_a_base_i,
    input  logic [ADDR_W-1:0]  job_b_base_i,
    input  logic [ADDR_W-1:0]  job_c_base_i,
    input  logic [SCALE_W-1:0] job_scale_a_i,
    input  logic [SCALE_W-1:0] job_scale_b_i,
    input  logic [QBW-1:0]     job_zp_a_i,
    input  logic [QBW-1:0]     job_zp_b_i,
    output logic [SCALE_W-1:0] cfg_scale_a_o,
    output logic [SCALE_W-1:0] cfg_scale_b_o,
    output logic [QBW-1:0]     cfg_zp_a_o,
    output logic [QBW-1:0]     cfg_zp_b_o,
    output logic               ld_valid_o,
    input  logic               ld_ready_i,
    output logic [ADDR_W-1:0]  ld_a_addr_o,
    output logic [ADDR_W-1:0]  ld_b_addr_o,
    output logic               ld_reuse_a_o,
    input  logic               ld_done_i,
    output logic               eng_start_o,
    input  logic               eng_done_i,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [ADDR_W-1:0]  wb_c_addr_o,
    input  logic               wb_done_i,
    output logic               busy_o,
    output logic [DIM_W-1:0]   tile_m_o,
    output logic [DIM_W-1:0]   tile_n_o,
    output logic               job_done_o,
    output logic               job_err_o
);

    localparam int E    = FP_W / 8;
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(TILE * K * E);
    localparam logic [ADDR_W-1:0] B_STEP = ADDR_W'(TILE * E);

    typedef enum logic [3:0] {
        S_IDLE, S_LD_REQ, S_LD_WAIT, S_START, S_COMP_WAIT,
        S_WB_REQ, S_WB_WAIT, S_NEXT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIM_W-1:0]    tile_m_q, tile_m_d, tile_n_q, tile_n_d;
    logic [DIM_W-1:0]    tiles_m_q, tiles_m_d, tiles_n_q, tiles_n_d;
    logic [ADDR_W-1:0]   b_base_q, b_base_d, c_row_q, c_row_d, c_stride_q, c_stride_d;
    logic [ADDR_W-1:0]   ld_a_q, ld_a_d, ld_b_q, ld_b_d, wb_c_q, wb_c_d;
    logic [SCALE_W-1:0]  scale_a_q, scale_a_d, scale_b_q, scale_b_d;
    logic [QBW-1:0]      zp_a_q, zp_a_d, zp_b_q, zp_b_d;
    logic [WD_W-1:0]     wd_q, wd_d, wd_inc;
    logic                err_q, err_d;
    logic                eng_done_q;
    logic                job_done_q, job_err_q;
    logic                eng_rise, bad_dims;

    assign eng_rise = eng_done_i & ~eng_done_q;
    assign wd_inc   = wd_q + WD_W'(1);
    assign bad_dims = (job_m_i == '0) || (job_n_i == '0) ||
                      ((job_m_i % DIM_W'(TILE)) != '0) || ((job_n_i % DIM_W'(TILE)) != '0);

    always_comb begin
        state_d    = state_q;
        tile_m_d   = tile_m_q;
        tile_n_d   = tile_n_q;
        tiles_m_d  = tiles_m_q;
        tiles_n_d  = tiles_n_q;
        b_base_d   = b_base_q;
        c_row_d    = c_row_q;
        c_stride_d = c_stride_q;
        ld_a_d     = ld_a_q;
        ld_b_d     = ld_b_q;
        wb_c_d     = wb_c_q;
        scale_a_d  = scale_a_q;
        scale_b_d  = scale_b_q;
        zp_a_d     = zp_a_q;
        zp_b_d     = zp_b_q;
        wd_d       = wd_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (job_valid_i) begin
                    scale_a_d  = job_scale_a_i;
                    scale_b_d  = job_scale_b_i;
                    zp_a_d     = job_zp_a_i;
                    zp_b_d     = job_zp_b_i;
                    tiles_m_d  = job_m_i / DIM_W'(TILE);
                    tiles_n_d  = job_n_i / DIM_W'(TILE);
                    b_base_d   = job_b_base_i;
                    c_row_d    = job_c_base_i;
                    c_stride_d = ADDR_W'(job_n_i) * B_STEP;
                    ld_a_d     = job_a_base_i;
                    ld_b_d     = job_b_base_i;
                    wb_c_d     = job_c_base_i;
                    tile_m_d   = '0;
                    tile_n_d   = '0;
                    err_d      = bad_dims;
                    state_d    = bad_dims ? S_DONE : S_LD_REQ;
                end
            end
            S_LD_REQ: begin
                if (ld_ready_i) state_d = ld_done_i ? S_START : S_LD_WAIT;
            end
            S_LD_WAIT: begin
                if (ld_done_i) state_d = S_START;
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_COMP_WAIT;
            end
            S_COMP_WAIT: begin
                // eng_done is a level; only a fresh rise belongs to this tile
                if (eng_rise) begin
                    state_d = S_WB_REQ;
                end else if (wd_inc == WD_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_inc;
                end
            end
            S_WB_REQ: begin
                if (wb_ready_i) state_d = wb_done_i ? S_NEXT : S_WB_WAIT;
            end
            S_WB_WAIT: begin
                if (wb_done_i) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (tile_n_q != tiles_n_q - DIM_W'(1)) begin
                    tile_n_d = tile_n_q + DIM_W'(1);
                    ld_b_d   = ld_b_q + B_STEP;
                    wb_c_d   = wb_c_q + B_STEP;
                    state_d  = S_LD_REQ;
                end else if (tile_m_q != tiles_m_q - DIM_W'(1)) begin
                    tile_n_d = '0;
                    tile_m_d = tile_m_q + DIM_W'(1);
                    ld_a_d   = ld_a_q + A_STEP;
                    ld_b_d   = b_base_q;
                    c_row_d  = c_row_q + c_stride_q;
                    wb_c_d   = c_row_q + c_stride_q;
                    state_d  = S_LD_REQ;
                end else begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tile_m_q   <= '0;
            tile_n_q   <= '0;
            tiles_m_q  <= '0;
            tiles_n_q  <= '0;
            b_base_q   <= '0;
            c_row_q    <= '0;
            c_stride_q <= '0;
            ld_a_q     <= '0;
            ld_b_q     <= '0;
            wb_c_q     <= '0;
            scale_a_q  <= '0;
            scale_b_q  <= '0;
            zp_a_q     <= '0;
            zp_b_q     <= '0;
            wd_q       <= '0;
            err_q      <= 1'b0;
            eng_done_q <= 1'b0;
            job_done_q <= 1'b0;
            job_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tile_m_q   <= tile_m_d;
            tile_n_q   <= tile_n_d;
            tiles_m_q  <= tiles_m_d;
            tiles_n_q  <= tiles_n_d;
            b_base_q   <= b_base_d;
            c_row_q    <= c_row_d;
            c_stride_q <= c_stride_d;
            ld_a_q     <= ld_a_d;
            ld_b_q     <= ld_b_d;
            wb_c_q     <= wb_c_d;
            scale_a_q  <= scale_a_d;
            scale_b_q  <= scale_b_d;
            zp_a_q     <= zp_a_d;
            zp_b_q     <= zp_b_d;
            wd_q       <= wd_d;
            err_q      <= err_d;
            eng_done_q <= eng_done_i;
            job_done_q <= (state_q == S_DONE);
            job_err_q  <= (state_q == S_DONE) && err_q;
        end
    end

    assign job_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign ld_valid_o    = (state_q == S_LD_REQ);
    assign eng_start_o   = (state_q == S_START);
    assign wb_valid_o    = (state_q == S_WB_REQ);
    assign ld_a_addr_o   = ld_a_q;
    assign ld_b_addr_o   = ld_b_q;
    assign ld_reuse_a_o  = (tile_n_q != '0);
    assign wb_c_addr_o   = wb_c_q;
    assign tile_m_o      = tile_m_q;
    assign tile_n_o      = tile_n_q;
    assign cfg_scale_a_o = scale_a_q;
    assign cfg_scale_b_o = scale_b_q;
    assign cfg_zp_a_o    = zp_a_q;
    assign cfg_zp_b_o    = zp_b_q;
    assign job_done_o    = job_done_q;
    assign job_err_o     = job_err_q;

endmodule

// File: tb/tb_qgemm_tile_sched.sv
// Directed bench for qgemm_tile_sched with behavioural loader, writer and engine responders.
module tb_qgemm_tile_sched;
    localparam int TILE = 8, K = 64, FP_W = 32, ADDR_W = 32, DIM_W = 16;
    localparam int SCALE_W = 16, QBW = 8, TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst;
    logic job_valid, job_ready;
    logic [DIM_W-1:0] job_m, job_n;
    logic [ADDR_W-1:0] job_a_base, job_b_base, job_c_base;
    logic [SCALE_W-1:0] job_scale_a, job_scale_b, cfg_scale_a, cfg_scale_b;
    logic [QBW-1:0] job_zp_a, job_zp_b, cfg_zp_a, cfg_zp_b;
    logic ld_valid, ld_ready, ld_reuse_a, ld_done;
    logic [ADDR_W-1:0] ld_a_addr, ld_b_addr, wb_c_addr;
    logic eng_start, eng_done, wb_valid, wb_ready, wb_done, busy, job_done, job_err;
    logic [DIM_W-1:0] tile_m, tile_n;

    qgemm_tile_sched #(.TILE(TILE), .K(K), .FP_W(FP_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W),
                       .SCALE_W(SCALE_W), .QBW(QBW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .job_valid_i(job_valid), .job_ready_o(job_ready),
        .job_m_i(job_m), .job_n_i(job_n),
        .job_a_base_i(job_a_base), .job_b_base_i(job_b_base), .job_c_base_i(job_c_base),
        .job_scale_a_i(job_scale_a), .job_scale_b_i(job_scale_b),
        .job_zp_a_i(job_zp_a), .job_zp_b_i(job_zp_b),
        .cfg_scale_a_o(cfg_scale_a), .cfg_scale_b_o(cfg_scale_b),
        .cfg_zp_a_o(cfg_zp_a), .cfg_zp_b_o(cfg_zp_b),
        .ld_valid_o(ld_valid), .ld_ready_i(ld_ready), .ld_a_addr_o(ld_a_addr),
        .ld_b_addr_o(ld_b_addr), .ld_reuse_a_o(ld_reuse_a), .ld_done_i(ld_done),
        .eng_start_o(eng_start), .eng_done_i(eng_done),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_c_addr_o(wb_c_addr), .wb_done_i(wb_done),
        .busy_o(busy), .tile_m_o(tile_m), .tile_n_o(tile_n),
        .job_done_o(job_done), .job_err_o(job_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] st_q[$], lda_q[$], ldb_q[$], wbc_q[$];
    logic        reuse_q[$];
    int          lat_q[$];
    int start_cyc = 0, done_cyc = 0, acc_cyc = 0;
    int done_cnt = 0, ldv_cnt = 0, wbv_cnt = 0, wb_hs_cnt = 0;
    logic last_err = 1'b0, wb_prev = 1'b0, ld_hs_prev = 1'b0, wb_hs_prev = 1'b0;

    always @(negedge clk) begin
        if (job_valid && job_ready) acc_cyc = cyc;
        if (eng_start) begin
            st_q.push_back({tile_m, tile_n});
            start_cyc = cyc;
        end
        if (ld_valid && ld_ready) begin
            lda_q.push_back(ld_a_addr);
            ldb_q.push_back(ld_b_addr);
            reuse_q.push_back(ld_reuse_a);
        end
        if (wb_valid && wb_ready) begin
            wbc_q.push_back(wb_c_addr);
            wb_hs_cnt++;
        end
        if (wb_valid && !wb_prev) lat_q.push_back(cyc - start_cyc);
        wb_prev    = wb_valid;
        ld_hs_prev = ld_valid && ld_ready;
        wb_hs_prev = wb_valid && wb_ready;
        if (ld_valid) ldv_cnt++;
        if (wb_valid) wbv_cnt++;
        if (job_done) begin
            done_cnt++;
            done_cyc = cyc;
            last_err = job_err;
        end
    end

    // Loader/writer: zero-latency by default, toggling ready with one-cycle-late done under bp
    logic bp = 1'b0, wb_hold = 1'b0;
    initial forever begin
        @(posedge clk); #1;
        if (bp) begin
            ld_ready = cyc[0];
            wb_ready = ~cyc[0];
            ld_done  = ld_hs_prev;
            wb_done  = wb_hs_prev & ~wb_hold;
        end else begin
            ld_ready = 1'b1;
            wb_ready = 1'b1;
            ld_done  = 1'b1;
            wb_done  = ~wb_hold;
        end
    end

    // Engine: mode 0 pulses done one cycle after start; 1 holds a level that dips for 20 cycles; 2 never finishes
    int eng_mode = 0, eng_cnt = 1000;
    initial forever begin
        @(posedge clk); #1;
        if (eng_start) eng_cnt = 0;
        else eng_cnt++;
        case (eng_mode)
            0: eng_done = (eng_cnt == 1);
            1: eng_done = !(eng_cnt >= 3 && eng_cnt < 23);
            default: eng_done = 1'b0;
        endcase
    end

    task automatic clear_logs();
        st_q.delete(); lda_q.delete(); ldb_q.delete(); wbc_q.delete();
        reuse_q.delete(); lat_q.delete();
        done_cnt = 0; ldv_cnt = 0; wbv_cnt = 0; wb_hs_cnt = 0;
    endtask

    task automatic submit(input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] n,
                          input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                          input logic [ADDR_W-1:0] c);
        @(posedge clk); #1;
        job_m = m; job_n = n; job_a_base = a; job_b_base = b; job_c_base = c;
        job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int k = 0; k < budget && done_cnt == 0; k++) @(negedge clk);
        chk({tag, "_done"}, done_cnt, 1);
    endtask

    logic [31:0] exp_tile [6] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002,
                                  32'h0001_0000, 32'h0001_0001, 32'h0001_0002};
    logic [31:0] exp_wbc  [6] = '{32'h1000, 32'h1020, 32'h1040, 32'h1300, 32'h1320, 32'h1340};

    initial begin
        logic [5:0] reuse_vec;
        rst = 1'b1; job_valid = 1'b0; job_m = '0; job_n = '0;
        job_a_base = '0; job_b_base = '0; job_c_base = '0;
        job_scale_a = 16'h1234; job_scale_b = 16'h5678; job_zp_a = 8'h11; job_zp_b = 8'h22;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_busy", {job_ready, busy}, 2'b10);
        chk("rst_req_outs", {ld_valid, wb_valid, eng_start, job_done, job_err}, 5'b0);
        chk("rst_cfg", {cfg_scale_a, cfg_scale_b, cfg_zp_a, cfg_zp_b}, 48'h0);
        @(posedge clk); #1 rst = 1'b0;

        // 2x3 tiles, zero-latency responders
        clear_logs();
        submit(16, 24, 32'h0001_0000, 32'h0002_0000, 32'h0000_1000);
        wait_done(400, "t1");
        chk("t1_err", last_err, 1'b0);
        chk("t1_starts", st_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < st_q.size())  chk($sformatf("t1_tile%0d", i), st_q[i], exp_tile[i]);
            if (i < wbc_q.size()) chk($sformatf("t1_wbc%0d", i), wbc_q[i], exp_wbc[i]);
        end
        reuse_vec = '0;
        for (int i = 0; i < 6 && i < reuse_q.size(); i++) reuse_vec[5-i] = reuse_q[i];
        chk("t1_reuse", reuse_vec, 6'b011011);
        if (lda_q.size() == 6) begin
            chk("t1_lda0", lda_q[0], 32'h0001_0000);
            chk("t1_lda3", lda_q[3], 32'h0001_0800);
            chk("t1_ldb2", ldb_q[2], 32'h0002_0040);
            chk("t1_ldb3", ldb_q[3], 32'h0002_0000);
        end else chk("t1_ld_count", lda_q.size(), 6);
        chk("t1_cfg", {cfg_scale_a, cfg_scale_b, cfg_zp_a, cfg_zp_b}, 48'h1234_5678_1122);
        chk("t1_idle", {job_ready, busy}, 2'b10);

        // engine done held high across tiles: only the rising edge completes
        eng_mode = 1;
        clear_logs();
        submit(8, 16, 32'h0, 32'h0, 32'h0);
        wait_done(400, "t2");
        chk("t2_err", last_err, 1'b0);
        chk("t2_starts", st_q.size(), 2);
        chk("t2_lat_cnt", lat_q.size(), 2);
        for (int i = 0; i < 2 && i < lat_q.size(); i++) chk($sformatf("t2_lat%0d", i), lat_q[i], 24);

        // engine hang: watchdog
        eng_mode = 2;
        clear_logs();
        submit(8, 8, 32'h0, 32'h0, 32'h0);
        wait_done(300, "t3");
        chk("t3_err", last_err, 1'b1);
        chk("t3_comp_to_done", done_cyc - (start_cyc + 1), 64);
        chk("t3_no_wb", wbv_cnt, 0);

        // bad dimensions
        eng_mode = 0;
        clear_logs();
        submit(12, 8, 32'h0, 32'h0, 32'h0);
        wait_done(20, "t4");
        chk("t4_err", last_err, 1'b1);
        chk("t4_acc_to_done", done_cyc - acc_cyc, 2);
        chk("t4_no_ld", ldv_cnt, 0);
        clear_logs();
        submit(8, 0, 32'h0, 32'h0, 32'h0);
        wait_done(20, "t4b");
        chk("t4b_err", last_err, 1'b1);

        // reset while waiting on writeback, under backpressure
        bp = 1'b1; wb_hold = 1'b1;
        clear_logs();
        submit(16, 16, 32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 300 && wb_hs_cnt == 0; k++) @(negedge clk);
        chk("t5_wb_hs", wb_hs_cnt, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_ready_busy", {job_ready, busy}, 2'b10);
        chk("t5_outs", {ld_valid, wb_valid, eng_start, job_done, job_err}, 5'b0);
        chk("t5_cfg_tile", {cfg_scale_a, cfg_zp_a, tile_m, tile_n}, 56'h0);
        repeat (10) @(negedge clk);
        chk("t5_no_done", done_cnt, 0);
        bp = 1'b0; wb_hold = 1'b0;
        clear_logs();
        submit(8, 8, 32'h0, 32'h0, 32'h40);
        wait_done(100, "t5b");
        chk("t5b_err", last_err, 1'b0);
        chk("t5b_starts", st_q.size(), 1);
        if (wbc_q.size() > 0) chk("t5b_wbc", wbc_q[0], 32'h40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
